hammu_job_arbiter: RTL and testbench

Round-robin job scheduler that shares a single `exponent` datapath (P = X^A) among `N_REQ` independent requesters. It accepts one (X, A) job at a time and sequences the datapath's load and start pulses. It then waits for done and returns P to the granted requester over a valid/ready response channel. It sits between the AXI4-Lite register front-ends and the `exponent` core, replacing the direct register-to-core wiring when several masters need the core.

---
 rtl/hammu_pkg.sv | 17 +
 rtl/hammu_rr_arbiter.sv | 32 +++
 rtl/hammu_job_arbiter.sv | 144 ++++++++++++++
 tb/tb_hammu_job_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hammu_pkg.sv
// Shared widths, FSM encoding and defaults for the hammu job arbiter.
package hammu_pkg;

  localparam int HAMMU_X_W            = 4;
  localparam int HAMMU_A_W            = 4;
  localparam int HAMMU_P_W            = 30;
  localparam int HAMMU_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } hammu_state_e;

endpackage

// File: rtl/hammu_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
module hammu_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    found     = 1'b0;
    idx       = 0;
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    any_req = found;
    grant   = found ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/hammu_job_arbiter.sv
// Round-robin scheduler sharing one exponent core among N_REQ requesters.
// Optional WAIT watchdog enabled by defining HAMMU_ARB_TIMEOUT_EN.
module hammu_job_arbiter
  import hammu_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int TIMEOUT_CYCLES = HAMMU_TIMEOUT_CYCLES,
  localparam int IDX_W          = $clog2(N_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*HAMMU_X_W-1:0] i_req_x,
  input  logic [N_REQ*HAMMU_A_W-1:0] i_req_a,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic [N_REQ-1:0]           o_rsp_valid,
  input  logic [N_REQ-1:0]           i_rsp_ready,
  output logic [HAMMU_P_W-1:0]       o_rsp_p,
`ifdef HAMMU_ARB_TIMEOUT_EN
  output logic                       o_rsp_err,
`endif
  output logic                       o_exp_load,
  output logic                       o_exp_start,
  output logic [HAMMU_X_W-1:0]       o_exp_x,
  output logic [HAMMU_A_W-1:0]       o_exp_a,
  input  logic                       i_exp_done,
  input  logic [HAMMU_P_W-1:0]       i_exp_p,
  output logic                       o_busy,
  output logic [IDX_W-1:0]           o_grant_id
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("hammu_job_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES positive");
  end

  hammu_state_e          state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      grant_id_q;
  logic [HAMMU_X_W-1:0]  x_q;
  logic [HAMMU_A_W-1:0]  a_q;
  logic [HAMMU_P_W-1:0]  p_q;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  accept;
  logic                  rsp_done;
  logic                  tmo_hit;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  hammu_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (i_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign accept   = (state_q == ST_IDLE) && arb_any;
  assign rsp_done = (state_q == ST_RESP) && i_rsp_ready[grant_id_q];

`ifdef HAMMU_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] tmo_cnt_q;
  logic            err_q;

  assign tmo_hit   = (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign o_rsp_err = err_q;

  // Watchdog: cleared on the way into WAIT, counts every WAIT cycle without done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_START) tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT && !i_exp_done) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (state_q == ST_WAIT) begin
        if (i_exp_done) err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d   = ST_LOAD;
          req_ready = arb_grant;
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (i_exp_done || tmo_hit) state_d = ST_RESP;
      ST_RESP:  if (i_rsp_ready[grant_id_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control and datapath latches; everything returns to zero on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      x_q        <= '0;
      a_q        <= '0;
      p_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_id_q <= arb_idx;
        x_q        <= i_req_x[arb_idx*HAMMU_X_W +: HAMMU_X_W];
        a_q        <= i_req_a[arb_idx*HAMMU_A_W +: HAMMU_A_W];
      end
      if (state_q == ST_WAIT) begin
        if (i_exp_done) p_q <= i_exp_p;
        else if (tmo_hit) p_q <= '0;
      end
      if (rsp_done) rr_ptr_q <= ptr_after(grant_id_q);
    end
  end

  // Accept must be visible in the same IDLE cycle, so ready is the only decoded input path.
  assign o_req_ready = i_rst ? '0 : req_ready;
  assign o_rsp_valid = (state_q == ST_RESP) ? (N_REQ'(1) << grant_id_q) : '0;
  assign o_rsp_p     = p_q;
  assign o_exp_load  = (state_q == ST_LOAD);
  assign o_exp_start = (state_q == ST_START);
  assign o_exp_x     = x_q;
  assign o_exp_a     = a_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_grant_id  = grant_id_q;

endmodule

// File: tb/tb_hammu_job_arbiter.sv
// Scoreboard bench for hammu_job_arbiter with an exponent-core stub and a round-robin reference model.
module tb_hammu_job_arbiter;
  import hammu_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int IW = $clog2(N);
  localparam longint unsigned PMOD = 64'd1 << 30;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [N-1:0]    i_req_valid = '0;
  logic [N*4-1:0]  i_req_x = '0;
  logic [N*4-1:0]  i_req_a = '0;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_rsp_valid;
  logic [N-1:0]    i_rsp_ready = '1;
  logic [29:0]     o_rsp_p;
`ifdef HAMMU_ARB_TIMEOUT_EN
  logic            o_rsp_err;
`endif
  logic            o_exp_load, o_exp_start;
  logic [3:0]      o_exp_x, o_exp_a;
  logic            i_exp_done = 1'b0;
  logic [29:0]     i_exp_p = '0;
  logic            o_busy;
  logic [IW-1:0]   o_grant_id;

  always #5 i_clk = ~i_clk;

  hammu_job_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_x     (i_req_x),
    .i_req_a     (i_req_a),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_p     (o_rsp_p),
`ifdef HAMMU_ARB_TIMEOUT_EN
    .o_rsp_err   (o_rsp_err),
`endif
    .o_exp_load  (o_exp_load),
    .o_exp_start (o_exp_start),
    .o_exp_x     (o_exp_x),
    .o_exp_a     (o_exp_a),
    .i_exp_done  (i_exp_done),
    .i_exp_p     (i_exp_p),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id)
  );

  // Exponent core stub: done some cycles after start, held until the next load.
  int         stub_cnt  = 0;
  logic [3:0] stub_x    = '0;
  logic [3:0] stub_a    = '0;
  int         stub_lat  = 3;
  bit         stub_hang = 1'b0;
  bit         stub_rand = 1'b0;

  function automatic logic [29:0] core_pow(logic [3:0] x, logic [3:0] a);
    longint unsigned r = 1;
    for (int i = 0; i < int'(a); i++) r = (r * x) % PMOD;
    return r[29:0];
  endfunction

  always @(posedge i_clk) begin
    if (o_exp_load) begin
      stub_x     <= o_exp_x;
      stub_a     <= o_exp_a;
      i_exp_done <= 1'b0;
      stub_cnt   <= 0;
    end else if (o_exp_start) begin
      stub_cnt <= stub_rand ? int'($urandom_range(1, 6)) : stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) begin
        i_exp_done <= 1'b1;
        i_exp_p    <= core_pow(stub_x, stub_a);
      end
    end
  end

  // Reference model and scoreboard
  typedef struct {
    int              id;
    int              x;
    int              a;
    longint unsigned p;
    bit              err;
  } job_t;

  job_t sb_q[$];
  int   grant_log[$];
  job_t mj;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, mptr = 0, w = -1;
  int   load_due = -10, start_due = -10, wait_start = -10, rsp_due = -10;
  bit   wait_armed = 1'b0, in_resp = 1'b0, zero_chk = 1'b0;
  logic [N-1:0] exp_rdy, exp_rv;

  function automatic longint unsigned ref_pow(int x, int a);
    longint unsigned r = 1, b = longint'(x);
    int e = a;
    while (e > 0) begin
      if (e & 1) r = (r * b) % PMOD;
      b = (b * b) % PMOD;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_bound(string name);
    n_chk++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      sb_q.delete();
      mptr = 0; zero_chk = 1'b1; wait_armed = 1'b0; in_resp = 1'b0;
      load_due = -10; start_due = -10; rsp_due = -10;
    end else begin
      if (zero_chk) begin
        zero_chk = 1'b0;
        chk("rst_busy",  o_busy, 0);
        chk("rst_load",  o_exp_load, 0);
        chk("rst_start", o_exp_start, 0);
        chk("rst_x",     o_exp_x, 0);
        chk("rst_a",     o_exp_a, 0);
        chk("rst_p",     o_rsp_p, 0);
        chk("rst_gid",   o_grant_id, 0);
        chk("rst_rv",    o_rsp_valid, 0);
      end
      w       = (sb_q.size() == 0) ? rr_pick(i_req_valid, mptr) : -1;
      exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
      chk("req_ready", o_req_ready, exp_rdy);
      chk("busy", o_busy, sb_q.size() != 0);
      chk("exp_load", o_exp_load, cyc == load_due);
      chk("exp_start", o_exp_start, cyc == start_due);
      if (cyc == load_due) begin
        chk("exp_x", o_exp_x, sb_q[0].x);
        chk("exp_a", o_exp_a, sb_q[0].a);
      end
      if (cyc == rsp_due) in_resp = 1'b1;
      exp_rv = in_resp ? (N'(1) << sb_q[0].id) : '0;
      chk("rsp_valid", o_rsp_valid, exp_rv);
      if (in_resp) begin
        chk("rsp_p", o_rsp_p, sb_q[0].p);
        chk("grant_id", o_grant_id, sb_q[0].id);
`ifdef HAMMU_ARB_TIMEOUT_EN
        chk("rsp_err", o_rsp_err, sb_q[0].err);
`endif
        if (i_rsp_ready[sb_q[0].id]) begin
          mptr = (sb_q[0].id + 1) % N;
          void'(sb_q.pop_front());
          in_resp = 1'b0;
        end
      end
      if (wait_armed && cyc >= wait_start) begin
        if (i_exp_done) begin
          rsp_due = cyc + 1; wait_armed = 1'b0;
        end
`ifdef HAMMU_ARB_TIMEOUT_EN
        else if (cyc == wait_start + TO - 1) begin
          rsp_due = cyc + 1; wait_armed = 1'b0;
          sb_q[0].p = 0; sb_q[0].err = 1'b1;
        end
`endif
      end
      if (w >= 0) begin
        mj.id  = w;
        mj.x   = int'(i_req_x[4*w +: 4]);
        mj.a   = int'(i_req_a[4*w +: 4]);
        mj.p   = ref_pow(mj.x, mj.a);
        mj.err = 1'b0;
        sb_q.push_back(mj);
        grant_log.push_back(w);
        load_due = cyc + 1; start_due = cyc + 2; wait_start = cyc + 3; wait_armed = 1'b1;
      end
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_req_valid = '0; i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic serve(int bound);
    logic [N-1:0] acc;
    int n = 0;
    while (i_req_valid != '0) begin
      @(negedge i_clk); acc = o_req_ready;
      tick();
      i_req_valid = i_req_valid & ~acc;
      n++;
      if (n > bound) begin fail_bound("serve"); i_req_valid = '0; end
    end
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    @(negedge i_clk);
    while (o_busy && n <= bound) begin @(negedge i_clk); n++; end
    if (n > bound) fail_bound("wait_idle");
    tick();
  endtask

  task automatic set_job(int k, int x, int a);
    i_req_x[4*k +: 4] = 4'(x);
    i_req_a[4*k +: 4] = 4'(a);
  endtask

  task automatic issue_expect(int k, int x, int a, longint unsigned expp);
    int n = 0;
    set_job(k, x, a);
    i_req_valid[k] = 1'b1;
    serve(100);
    while (!o_rsp_valid[k] && n < 200) begin tick(); n++; end
    if (n >= 200) fail_bound("rsp_wait");
    else chk("direct_p", o_rsp_p, expp);
    wait_idle(200);
  endtask

  initial begin
    int base, n;
    logic [N-1:0] acc;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    do_reset();

    // single job from requester 0
    issue_expect(0, 2, 3, 8);

    // all requesters continuously valid, pointer restarted at 0
    do_reset();
    stub_rand = 1'b1;
    set_job(0, 3, 4); set_job(1, 2, 5); set_job(2, 5, 2); set_job(3, 7, 1);
    base = grant_log.size(); n = 0;
    i_req_valid = '1;
    while (grant_log.size() < base + 5 && n < 500) begin tick(); n++; end
    i_req_valid = '0;
    if (n >= 500) fail_bound("rr_run");
    wait_idle(200);
    for (int i = 0; i < 5; i++)
      if (base + i < grant_log.size()) chk("rr_order", grant_log[base+i], exp_order[i]);

    // reset two cycles into WAIT abandons the job
    stub_rand = 1'b0; stub_lat = 10;
    set_job(0, 4, 4);
    i_req_valid[0] = 1'b1;
    serve(100);
    n = 0;
    while (!o_exp_start && n < 50) begin tick(); n++; end
    tick(); tick();
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    repeat (15) tick();
    stub_rand = 1'b1;
    issue_expect(1, 3, 2, 9);

    // pointer wrap: job on 2 leaves pointer at 3, then only requester 1 asks
    issue_expect(2, 1, 5, 1);
    issue_expect(1, 6, 2, 36);
    chk("wrap_grant", grant_log[grant_log.size()-1], 1);

    // held response on requester 2 while 0 and 1 wait
    set_job(0, 1, 1); set_job(1, 4, 2); set_job(2, 3, 4);
    i_rsp_ready = 4'b1011;
    i_req_valid = 4'b0111;
    base = grant_log.size(); n = 0;
    while (!o_rsp_valid[2] && n < 100) begin
      @(negedge i_clk); acc = o_req_ready;
      tick();
      i_req_valid = i_req_valid & ~acc;
      n++;
    end
    if (n >= 100) fail_bound("hold_wait");
    repeat (5) begin
      chk("hold_valid", o_rsp_valid, 4'b0100);
      chk("hold_p", o_rsp_p, 81);
      tick();
    end
    i_rsp_ready = '1;
    serve(100);
    wait_idle(200);
    if (grant_log.size() >= base + 3) begin
      chk("hold_order0", grant_log[base], 2);
      chk("hold_order1", grant_log[base+1], 0);
      chk("hold_order2", grant_log[base+2], 1);
    end else fail_bound("hold_grants");

`ifdef HAMMU_ARB_TIMEOUT_EN
    stub_hang = 1'b1;
    issue_expect(0, 2, 2, 0);
    stub_hang = 1'b0;
`endif

    // randomized traffic with back-pressure and withdrawn requests
    stub_rand = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge i_clk); acc = o_req_ready;
      tick();
      for (int k = 0; k < N; k++) begin
        if (acc[k]) i_req_valid[k] = 1'b0;
        else if (!i_req_valid[k] && $urandom_range(0, 3) == 0) begin
          set_job(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
          i_req_valid[k] = 1'b1;
        end else if (i_req_valid[k] && $urandom_range(0, 19) == 0) i_req_valid[k] = 1'b0;
      end
      i_rsp_ready = N'($urandom_range(0, 15));
    end
    i_req_valid = '0;
    i_rsp_ready = '1;
    wait_idle(200);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (%0d checks so far)", n_chk);
    $fatal(1);
  end

endmodule
